// File: rtl/popcount_enum_int8.sv
// popcount_enum_int8
//   Enumerates, in increasing numeric order, every WIDTH-bit word whose
//   popcount equals a requested K. One word is offered per beat on a
//   valid/ready stream; a new word follows every accepted beat.
//
//   Optional feature macro: POPCOUNT_ENUM_IDX_EN adds the IDX rank output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new enumeration (honoured only while idle)
//   K          target popcount, sampled with start
//   busy       high from the cycle after start until the last beat is accepted
//   out_valid  Y is valid
//   out_ready  consumer accepts Y when out_valid && out_ready
//   Y          current enumerated word
//   last       Y is the final word of the run (qualified by out_valid)
//   err        one-cycle pulse after a start with K > WIDTH
//   IDX        rank of Y starting at 0 (POPCOUNT_ENUM_IDX_EN only)
module popcount_enum_int8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] K,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             last,
    output logic             err
`ifdef POPCOUNT_ENUM_IDX_EN
    ,
    output logic [IDX_W-1:0] IDX
`endif
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [CNT_W-1:0] WIDTH_K = CNT_W'(WIDTH);

    // Word with the k lowest bits set: the smallest word of popcount k.
    function automatic logic [WIDTH-1:0] low_ones(input logic [CNT_W-1:0] k);
        logic [31:0] kk;
        logic [WIDTH-1:0] m;
        kk = 32'(k);
        m  = '0;
        for (int i = 0; i < WIDTH; i++) m[i] = (32'(i) < kk);
        return m;
    endfunction

    // Word with the k highest bits set: the largest word of popcount k.
    function automatic logic [WIDTH-1:0] high_ones(input logic [CNT_W-1:0] k);
        logic [31:0] kk;
        logic [WIDTH-1:0] m;
        kk = 32'(k);
        m  = '0;
        for (int i = 0; i < WIDTH; i++) m[i] = (32'(i) + kk >= 32'(WIDTH));
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] trailing_zeros(input logic [WIDTH-1:0] x);
        logic [CNT_W-1:0] tz;
        tz = WIDTH_K;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) tz = CNT_W'(i);
        end
        return tz;
    endfunction

    // Gosper step: next larger word with the same popcount, no divider.
    // The lowest run of ones is carried up by one, and the remaining
    // ones of that run are shifted back down to bit 0.
    function automatic logic [WIDTH-1:0] gosper_next(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] c;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] low;
        c   = x & (~x + 1'b1);
        r   = {1'b0, x} + {1'b0, c};
        low = ((x ^ r[WIDTH-1:0]) >> 2) >> trailing_zeros(x);
        // A carry-out only happens past the final word; never wrap silently.
        return r[WIDTH] ? '0 : (r[WIDTH-1:0] | low);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             at_last;

    assign at_last = (y_q == high_ones(k_q));

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        k_d     = k_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (K > WIDTH_K) begin
                        err_d = 1'b1;
                    end else begin
                        y_d     = low_ones(K);
                        k_d     = K;
                        idx_d   = '0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                // start is deliberately not looked at here.
                if (out_ready) begin
                    if (at_last) begin
                        y_d     = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        y_d   = gosper_next(y_q);
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == EMIT);
    assign out_valid = (state_q == EMIT);
    assign Y         = y_q;
    assign last      = (state_q == EMIT) && at_last;
    assign err       = err_q;

`ifdef POPCOUNT_ENUM_IDX_EN
    assign IDX = idx_q;
`else
    // Rank counter has no observer without the IDX port.
    logic unused_idx;
    assign unused_idx = ^idx_q;
`endif

endmodule

// File: tb/tb_popcount_enum_int8.sv
module tb_popcount_enum_int8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] K = '0;
    logic       busy, out_valid, out_ready, last, err;
    logic [7:0] Y;
`ifdef POPCOUNT_ENUM_IDX_EN
    logic [7:0] IDX;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] y;
        logic       last;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];

    popcount_enum_int8 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .K(K),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .last(last), .err(err)
`ifdef POPCOUNT_ENUM_IDX_EN
        , .IDX(IDX)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: brute-force scan of all words, independent of any Gosper step.
    task automatic push_model(input int k);
        int idx = 0;
        for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == k) begin
                sb.push_back('{y: v[7:0], last: 1'b0, idx: idx[7:0]});
                idx++;
            end
        end
        sb[sb.size()-1].last = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k);
        start = 1'b1;
        K = k[3:0];
        if (k <= 8) push_model(k);
        tick();
        start = 1'b0;
        if (k <= 8) check("first_valid_latency", out_valid, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_Y"}, Y, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_err"}, err, 0);
`ifdef POPCOUNT_ENUM_IDX_EN
        check({tag, "_IDX"}, IDX, 0);
`endif
    endtask

    // Consume scoreboard entries as the DUT offers them; stop after max_beats.
    task automatic drain(input bit rand_ready, input int max_beats, input int budget);
        int n = 0;
        int beats = 0;
        bit stalled = 0;
        logic [7:0] py;
        logic pl;
`ifdef POPCOUNT_ENUM_IDX_EN
        logic [7:0] pi;
`endif
        exp_t e;
        while (sb.size() > 0 && beats < max_beats && n < budget) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("stall_Y", Y, py);
                check("stall_last", last, pl);
`ifdef POPCOUNT_ENUM_IDX_EN
                check("stall_IDX", IDX, pi);
`endif
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("beat_Y", Y, e.y);
                check("beat_last", last, e.last);
`ifdef POPCOUNT_ENUM_IDX_EN
                check("beat_IDX", IDX, e.idx);
`endif
                beats++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                py = Y;
                pl = last;
`ifdef POPCOUNT_ENUM_IDX_EN
                pi = IDX;
`endif
            end
            tick();
            n++;
        end
        out_ready = 1'b0;
        if (n >= budget) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int errs;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_idle_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_zero("post_reset");

        // K=2, always ready: 28 beats, then idle
        do_start(2);
        drain(1'b0, 1000, 200);
        check("k2_remaining", sb.size(), 0);
        check("k2_busy_after", busy, 0);
        check("k2_valid_after", out_valid, 0);

        // K=0 and K=8: single-word runs
        do_start(0);
        drain(1'b0, 1000, 20);
        check("k0_busy_after", busy, 0);
        do_start(8);
        drain(1'b0, 1000, 20);
        check("k8_busy_after", busy, 0);

        // K=9: err pulse only
        start = 1'b1;
        K = 4'd9;
        tick();
        start = 1'b0;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            errs += int'(err);
            check("k9_valid", out_valid, 0);
            check("k9_busy", busy, 0);
            tick();
        end
        check("k9_err_cycles", errs, 1);

        // K=4 with random backpressure: 70 beats, ending at 0xF0
        do_start(4);
        drain(1'b1, 1000, 2000);
        check("k4_remaining", sb.size(), 0);
        check("k4_busy_after", busy, 0);

        // K=1 run with start K=3 held throughout, including last accept
        do_start(1);
        start = 1'b1;
        K = 4'd3;
        drain(1'b0, 1000, 50);
        start = 1'b0;
        check("k1_remaining", sb.size(), 0);
        check("k1_busy_after", busy, 0);
        tick();
        check("k1_no_restart", out_valid, 0);
        check("k1_no_err", err, 0);

        // Async reset mid-run, then a fresh K=1 run
        do_start(4);
        drain(1'b0, 10, 50);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrun_reset");
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1);
        drain(1'b0, 1000, 50);
        check("after_reset_remaining", sb.size(), 0);
        check("after_reset_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
